// File: rtl/sdram_init_seq_if.sv
// rtl/sdram_init_seq_if.sv - lock input, SDRAM command pins and init_done of the init sequencer
interface sdram_init_seq_if;
  logic        locked;
  logic        sdram_cke;
  logic [3:0]  sdram_cmd;
  logic [12:0] sdram_addr;
  logic [1:0]  sdram_ba;
  logic        init_done;

  modport master (
    input  locked,
    output sdram_cke, sdram_cmd, sdram_addr, sdram_ba, init_done
  );

  modport slave (
    output locked,
    input  sdram_cke, sdram_cmd, sdram_addr, sdram_ba, init_done
  );
endinterface

// File: rtl/sdram_init_seq.sv
// rtl/sdram_init_seq.sv - SDRAM power-up sequencer: clock wait, precharge-all, refreshes, mode load
// Wait parameters must be >= 1; NUM_REFRESH >= 1.
module sdram_init_seq #(
  parameter int unsigned POWERUP_CYCLES = 30000,
  parameter int unsigned TRP_CYCLES     = 3,
  parameter int unsigned TRFC_CYCLES    = 10,
  parameter int unsigned TMRD_CYCLES    = 2,
  parameter int unsigned NUM_REFRESH    = 8,
  parameter logic [12:0] MODE_REG       = 13'h033
) (
  input  logic             clk,
  input  logic             RESET,
  sdram_init_seq_if.master bus
);
  localparam int DW = $clog2(POWERUP_CYCLES + 1);
  localparam int RW = $clog2(NUM_REFRESH + 1);

  // POWERUP runs one cycle longer than the other waits: it spans the lock-sampling
  // edge to PRECHARGE, which lands POWERUP_CYCLES+1 edges later.
  localparam logic [DW-1:0] PU_LAST   = DW'(POWERUP_CYCLES);
  localparam logic [DW-1:0] TRP_LAST  = DW'(TRP_CYCLES - 1);
  localparam logic [DW-1:0] TRFC_LAST = DW'(TRFC_CYCLES - 1);
  localparam logic [DW-1:0] TMRD_LAST = DW'(TMRD_CYCLES - 1);
  localparam logic [RW-1:0] REF_TOTAL = RW'(NUM_REFRESH);

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_LMR = 4'b0000;

  typedef enum logic [3:0] {
    S_WAIT_LOCK,
    S_POWERUP,
    S_PRECHARGE,
    S_WAIT_TRP,
    S_REFRESH,
    S_WAIT_TRFC,
    S_LOAD_MODE,
    S_WAIT_TMRD,
    S_DONE
  } state_t;

  state_t        state;
  logic [DW-1:0] dcnt;
  logic [RW-1:0] rcnt;
  logic          cke_q;
  logic [3:0]    cmd_q;
  logic [12:0]   addr_q;
  logic [1:0]    ba_q;
  logic          done_q;

  always_ff @(posedge clk) begin
    if (RESET) begin
      state  <= S_WAIT_LOCK;
      dcnt   <= '0;
      rcnt   <= '0;
      cke_q  <= 1'b0;
      cmd_q  <= CMD_NOP;
      addr_q <= '0;
      ba_q   <= '0;
      done_q <= 1'b0;
    end else if (state != S_WAIT_LOCK && !bus.locked) begin
      // Lock loss overrides everything, including a command cycle in flight.
      state  <= S_WAIT_LOCK;
      dcnt   <= '0;
      rcnt   <= '0;
      cke_q  <= 1'b0;
      cmd_q  <= CMD_NOP;
      addr_q <= '0;
      ba_q   <= '0;
      done_q <= 1'b0;
    end else begin
      // Every command lasts one cycle; the bus falls back to an idle NOP by default.
      cmd_q  <= CMD_NOP;
      addr_q <= '0;
      ba_q   <= '0;
      case (state)
        S_WAIT_LOCK: begin
          if (bus.locked) begin
            state <= S_POWERUP;
            cke_q <= 1'b1;
            dcnt  <= '0;
          end
        end
        S_POWERUP: begin
          if (dcnt == PU_LAST) begin
            state  <= S_PRECHARGE;
            dcnt   <= '0;
            cmd_q  <= CMD_PRE;
            addr_q <= 13'h0400;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        S_PRECHARGE: state <= S_WAIT_TRP;
        S_WAIT_TRP: begin
          if (dcnt == TRP_LAST) begin
            state <= S_REFRESH;
            dcnt  <= '0;
            cmd_q <= CMD_REF;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        S_REFRESH: begin
          rcnt  <= rcnt + 1'b1;
          state <= S_WAIT_TRFC;
        end
        S_WAIT_TRFC: begin
          if (dcnt == TRFC_LAST) begin
            dcnt <= '0;
            if (rcnt < REF_TOTAL) begin
              state <= S_REFRESH;
              cmd_q <= CMD_REF;
            end else begin
              state  <= S_LOAD_MODE;
              cmd_q  <= CMD_LMR;
              addr_q <= MODE_REG;
            end
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        S_LOAD_MODE: state <= S_WAIT_TMRD;
        S_WAIT_TMRD: begin
          if (dcnt == TMRD_LAST) begin
            state  <= S_DONE;
            dcnt   <= '0;
            done_q <= 1'b1;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        S_DONE:  done_q <= 1'b1;
        default: state <= S_WAIT_LOCK;
      endcase
    end
  end

  assign bus.sdram_cke  = cke_q;
  assign bus.sdram_cmd  = cmd_q;
  assign bus.sdram_addr = addr_q;
  assign bus.sdram_ba   = ba_q;
  assign bus.init_done  = done_q;
endmodule

// File: tb/tb_sdram_init_seq.sv
// tb/tb_sdram_init_seq.sv - scoreboard bench for sdram_init_seq, short and default parameter sets
`timescale 1ns/1ps
module tb_sdram_init_seq;
  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] PRE = 4'b0010;
  localparam logic [3:0] REF = 4'b0001;
  localparam logic [3:0] LMR = 4'b0000;

  typedef struct packed {
    logic [31:0] cyc;
    logic        cke;
    logic [3:0]  cmd;
    logic [12:0] addr;
    logic [1:0]  ba;
    logic        done;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_a;
  logic        rst_b;
  int unsigned cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  ev_t         exp_a[$];
  ev_t         exp_b[$];
  bit          mon_a_en = 1'b0;
  bit          mon_b_en = 1'b0;
  bit          def_done = 1'b0;
  logic        prev_cke_a = 1'b0, prev_done_a = 1'b0;
  logic        prev_cke_b = 1'b0, prev_done_b = 1'b0;

  sdram_init_seq_if bus_a ();
  sdram_init_seq_if bus_b ();

  sdram_init_seq #(
    .POWERUP_CYCLES(10), .TRP_CYCLES(2), .TRFC_CYCLES(4),
    .TMRD_CYCLES(2), .NUM_REFRESH(2), .MODE_REG(13'h033)
  ) dut_a (.clk(clk), .RESET(rst_a), .bus(bus_a.master));

  sdram_init_seq dut_b (.clk(clk), .RESET(rst_b), .bus(bus_b.master));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic ev_t mk(int unsigned c, logic k, logic [3:0] cm, logic [12:0] a, logic [1:0] b, logic d);
    ev_t e;
    e.cyc = c; e.cke = k; e.cmd = cm; e.addr = a; e.ba = b; e.done = d;
    return e;
  endfunction

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic cmp_ev(string name, ev_t act, ev_t req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got cyc=%0d cke=%b cmd=%b addr=%h ba=%h done=%b, required cyc=%0d cke=%b cmd=%b addr=%h ba=%h done=%b",
               name, act.cyc, act.cke, act.cmd, act.addr, act.ba, act.done,
               req.cyc, req.cke, req.cmd, req.addr, req.ba, req.done);
    end
  endtask

  // Expected events of the short set for a lock sampled at edge e: first n of the sequence.
  task automatic push_a(int unsigned e, int n);
    ev_t s[6];
    s[0] = mk(e,      1'b1, NOP, 13'h000, 2'd0, 1'b0);
    s[1] = mk(e + 11, 1'b1, PRE, 13'h400, 2'd0, 1'b0);
    s[2] = mk(e + 14, 1'b1, REF, 13'h000, 2'd0, 1'b0);
    s[3] = mk(e + 19, 1'b1, REF, 13'h000, 2'd0, 1'b0);
    s[4] = mk(e + 24, 1'b1, LMR, 13'h033, 2'd0, 1'b0);
    s[5] = mk(e + 27, 1'b1, NOP, 13'h000, 2'd0, 1'b1);
    for (int i = 0; i < n; i++) exp_a.push_back(s[i]);
  endtask

  task automatic drop_lock_a();
    bus_a.locked = 1'b0;
    exp_a.push_back(mk(cyc + 1, 1'b0, NOP, 13'h000, 2'd0, 1'b0));
  endtask

  always @(negedge clk) begin
    ev_t act;
    act = mk(cyc, bus_a.sdram_cke, bus_a.sdram_cmd, bus_a.sdram_addr, bus_a.sdram_ba, bus_a.init_done);
    if (mon_a_en) begin
      if (act.cmd == NOP) check("idle_bus_zero_a", {17'd0, act.ba, act.addr}, 32'd0);
      if (act.cmd != NOP || act.cke != prev_cke_a || act.done != prev_done_a) begin
        if (exp_a.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_event_a: got cyc=%0d cke=%b cmd=%b addr=%h done=%b, required no event",
                   act.cyc, act.cke, act.cmd, act.addr, act.done);
        end else begin
          cmp_ev("event_a", act, exp_a.pop_front());
        end
      end
    end
    prev_cke_a  = act.cke;
    prev_done_a = act.done;
  end

  always @(negedge clk) begin
    ev_t act;
    act = mk(cyc, bus_b.sdram_cke, bus_b.sdram_cmd, bus_b.sdram_addr, bus_b.sdram_ba, bus_b.init_done);
    if (mon_b_en) begin
      if (act.cmd != NOP || act.cke != prev_cke_b || act.done != prev_done_b) begin
        if (exp_b.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_event_b: got cyc=%0d cke=%b cmd=%b addr=%h done=%b, required no event",
                   act.cyc, act.cke, act.cmd, act.addr, act.done);
        end else begin
          cmp_ev("event_b", act, exp_b.pop_front());
        end
      end
    end
    prev_cke_b  = act.cke;
    prev_done_b = act.done;
  end

  // Default parameter set: 30001 edges to PRECHARGE, 8 refreshes, done at +30096.
  initial begin
    int unsigned e;
    rst_b = 1'b1;
    bus_b.locked = 1'b0;
    step(2);
    rst_b = 1'b0;
    mon_b_en = 1'b1;
    step(3);
    bus_b.locked = 1'b1;
    e = cyc + 1;
    exp_b.push_back(mk(e, 1'b1, NOP, 13'h000, 2'd0, 1'b0));
    exp_b.push_back(mk(e + 30001, 1'b1, PRE, 13'h400, 2'd0, 1'b0));
    for (int i = 0; i < 8; i++)
      exp_b.push_back(mk(e + 30005 + 11 * i, 1'b1, REF, 13'h000, 2'd0, 1'b0));
    exp_b.push_back(mk(e + 30093, 1'b1, LMR, 13'h033, 2'd0, 1'b0));
    exp_b.push_back(mk(e + 30096, 1'b1, NOP, 13'h000, 2'd0, 1'b1));
    step(30100);
    def_done = 1'b1;
  end

  initial begin
    int unsigned e;
    int          n;
    rst_a = 1'b1;
    bus_a.locked = 1'b0;
    step(3);
    check("reset_cke",  {31'd0, bus_a.sdram_cke}, 32'd0);
    check("reset_cmd",  {28'd0, bus_a.sdram_cmd}, {28'd0, NOP});
    check("reset_addr", {19'd0, bus_a.sdram_addr}, 32'd0);
    check("reset_ba",   {30'd0, bus_a.sdram_ba}, 32'd0);
    check("reset_done", {31'd0, bus_a.init_done}, 32'd0);
    rst_a = 1'b0;
    mon_a_en = 1'b1;

    step(1000);
    check("nolock_cke",  {31'd0, bus_a.sdram_cke}, 32'd0);
    check("nolock_cmd",  {28'd0, bus_a.sdram_cmd}, {28'd0, NOP});
    check("nolock_done", {31'd0, bus_a.init_done}, 32'd0);

    step(5);
    bus_a.locked = 1'b1;
    e = cyc + 1;
    push_a(e, 6);
    step(31);

    drop_lock_a();
    step(5);
    bus_a.locked = 1'b1;
    e = cyc + 1;
    push_a(e, 6);
    step(31);

    drop_lock_a();
    step(5);
    bus_a.locked = 1'b1;
    e = cyc + 1;
    push_a(e, 4);
    step(22);
    drop_lock_a();
    step(5);
    bus_a.locked = 1'b1;
    e = cyc + 1;
    push_a(e, 6);
    step(31);

    drop_lock_a();
    step(5);
    bus_a.locked = 1'b1;
    e = cyc + 1;
    push_a(e, 5);
    step(25);
    rst_a = 1'b1;
    exp_a.push_back(mk(cyc + 1, 1'b0, NOP, 13'h000, 2'd0, 1'b0));
    step(1);
    check("midreset_cke",  {31'd0, bus_a.sdram_cke}, 32'd0);
    check("midreset_cmd",  {28'd0, bus_a.sdram_cmd}, {28'd0, NOP});
    check("midreset_addr", {19'd0, bus_a.sdram_addr}, 32'd0);
    rst_a = 1'b0;
    e = cyc + 1;
    push_a(e, 6);
    step(31);

    step(5);
    check("pending_events_a", exp_a.size(), 32'd0);

    n = 0;
    while (!def_done && n < 40000) begin
      step(1);
      n++;
    end
    if (!def_done) begin
      vectors++; miscompares++;
      $display("FAIL default_run_timeout: got not finished, required finished within 40000 cycles");
    end
    check("pending_events_b", exp_b.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
